// File: rtl/switch_conditioner.sv
// Front-panel switch conditioner: per-channel synchronizer, debounce FSM,
// clean active-low level and single-cycle press/release pulses.

module sw_channel #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 500000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic busy
);
    typedef enum logic [1:0] {
        STABLE_HI,
        WAIT_LO,
        STABLE_LO,
        WAIT_HI
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             level_nx, press_nx, rel_nx, busy_nx;

    // raw goes straight into the first flop; nothing combinational ahead of it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '1;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= STABLE_HI;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b0;
            rel   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            level <= level_nx;
            press <= press_nx;
            rel   <= rel_nx;
            busy  <= busy_nx;
        end
    end

    // Counter is cleared on every state entry and only compared for equality,
    // so any glitch during WAIT restarts the full qualification window.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        level_nx = level;
        press_nx = 1'b0;
        rel_nx   = 1'b0;
        case (state)
            STABLE_HI: begin
                if (!sync_out) begin
                    state_nx = WAIT_LO;
                    cnt_nx   = '0;
                end
            end
            WAIT_LO: begin
                if (sync_out) begin
                    state_nx = STABLE_HI;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = STABLE_LO;
                    cnt_nx   = '0;
                    level_nx = 1'b0;
                    press_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            STABLE_LO: begin
                if (sync_out) begin
                    state_nx = WAIT_HI;
                    cnt_nx   = '0;
                end
            end
            WAIT_HI: begin
                if (!sync_out) begin
                    state_nx = STABLE_LO;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = STABLE_HI;
                    cnt_nx   = '0;
                    level_nx = 1'b1;
                    rel_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = STABLE_HI;
                cnt_nx   = '0;
            end
        endcase
        busy_nx = (state_nx == WAIT_LO) || (state_nx == WAIT_HI);
    end
endmodule

module switch_conditioner #(
    parameter int unsigned NUM_SW      = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 500000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] swRaw,
    output logic [NUM_SW-1:0] swLevel,
    output logic [NUM_SW-1:0] swPress,
    output logic [NUM_SW-1:0] swRelease,
    output logic [NUM_SW-1:0] swBusy
);
    // bit 0 = CH, bit 1 = CE, bit 2 = CP; channels are fully independent
    for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
        sw_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .raw   (swRaw[i]),
            .level (swLevel[i]),
            .press (swPress[i]),
            .rel   (swRelease[i]),
            .busy  (swBusy[i])
        );
    end
endmodule

// File: tb/tb_switch_conditioner.sv
// Randomized + directed bench for switch_conditioner against a run-length
// reference model of the synchronized, debounced switch levels.

module tb_switch_conditioner;
    localparam int NSW = 3;
    localparam int SS  = 2;
    localparam int DEB = 4;
    localparam int CW  = 20;

    logic           clk = 1'b0;
    logic           rst;
    logic [NSW-1:0] swRaw;
    logic [NSW-1:0] swLevel, swPress, swRelease, swBusy;

    always #5 clk = ~clk;

    switch_conditioner #(
        .NUM_SW      (NSW),
        .SYNC_STAGES (SS),
        .DEB_CYCLES  (DEB),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .swRaw     (swRaw),
        .swLevel   (swLevel),
        .swPress   (swPress),
        .swRelease (swRelease),
        .swBusy    (swBusy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: the FSM sees raw delayed by SS edges; a level is accepted once
    // the delayed input has disagreed with it for DEB+1 consecutive edges.
    logic [NSW-1:0] m_lvl, m_press, m_rel, m_busy;
    logic [NSW-1:0] hist [SS];
    int             run  [NSW];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_lvl   = '1;
        m_press = '0;
        m_rel   = '0;
        m_busy  = '0;
        for (int j = 0; j < SS; j++) hist[j] = '1;
        for (int i = 0; i < NSW; i++) run[i] = 0;
    endtask

    task automatic model_step();
        logic [NSW-1:0] s;
        s = hist[SS-1];
        for (int j = SS - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = swRaw;
        for (int i = 0; i < NSW; i++) begin
            m_press[i] = 1'b0;
            m_rel[i]   = 1'b0;
            if (s[i] != m_lvl[i]) run[i]++;
            else                  run[i] = 0;
            if (run[i] == DEB + 1) begin
                m_lvl[i] = s[i];
                if (s[i]) m_rel[i] = 1'b1;
                else      m_press[i] = 1'b1;
                run[i] = 0;
            end
            m_busy[i] = (run[i] != 0);
        end
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".level"},   32'(swLevel),   32'(m_lvl));
        chk({tag, ".press"},   32'(swPress),   32'(m_press));
        chk({tag, ".release"}, 32'(swRelease), 32'(m_rel));
        chk({tag, ".busy"},    32'(swBusy),    32'(m_busy));
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_out(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        model_reset();
        #1;
        check_out({tag, ".rst"});
        repeat (2) @(negedge clk);
        check_out({tag, ".rst_hold"});
        rst = 1'b1;
    endtask

    // Runs n cycles and reports the edge index (0 = first edge) of the first
    // pulse on the selected channel bits, plus how many pulse cycles occurred.
    task automatic watch(input string tag, input int n, input logic [NSW-1:0] mask,
                         input bit want_rel, output int first_e, output int pulses);
        first_e = -1;
        pulses  = 0;
        for (int e = 0; e < n; e++) begin
            cycle(tag);
            if (((want_rel ? swRelease : swPress) & mask) == mask) begin
                pulses++;
                if (first_e < 0) first_e = e;
            end
        end
    endtask

    initial begin
        int fe, np, busy_seen;
        swRaw = '1;
        rst   = 1'b1;
        @(negedge clk);
        do_reset("init");

        // Idle
        for (int k = 0; k < 100; k++) cycle("idle");
        chk("idle.level", 32'(swLevel), 32'h7);

        // Clean press on CH
        swRaw[0] = 1'b0;
        fe = -1;
        for (int e = 0; e < 10; e++) begin
            cycle("press");
            if (e == 1) chk("press.busy_e1", 32'(swBusy[0]), 32'd0);
            if (e == 2) chk("press.busy_e2", 32'(swBusy[0]), 32'd1);
            if (e == 5) chk("press.level_e5", 32'(swLevel[0]), 32'd1);
            if (e == 6) chk("press.pulse_e6", 32'(swPress), 32'h1);
            if (e == 7) chk("press.pulse_e7", 32'(swPress[0]), 32'd0);
        end
        chk("press.level", 32'(swLevel), 32'h6);

        // Bounce on CE: 0,1,0,1 held two cycles each, then rests high
        busy_seen = 0;
        np = 0;
        for (int k = 0; k < 8; k++) begin
            swRaw[1] = k[1];
            cycle("bounce");
            busy_seen |= int'(swBusy[1]);
            np += int'(swPress[1]) + int'(swRelease[1]);
        end
        swRaw[1] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle("bounce");
            busy_seen |= int'(swBusy[1]);
            np += int'(swPress[1]) + int'(swRelease[1]);
        end
        chk("bounce.pulses", 32'(np), 32'd0);
        chk("bounce.busy", 32'(busy_seen), 32'd1);
        chk("bounce.level", 32'(swLevel[1]), 32'd1);

        // Release after hold on CP
        swRaw[2] = 1'b0;
        watch("cp_low", 12, 3'b100, 1'b0, fe, np);
        chk("cp_low.press_edge", 32'(fe), 32'd6);
        swRaw[2] = 1'b1;
        watch("cp_rel", 15, 3'b100, 1'b1, fe, np);
        chk("cp_rel.edge", 32'(fe), 32'd6);
        chk("cp_rel.count", 32'(np), 32'd1);
        chk("cp_rel.level", 32'(swLevel[2]), 32'd1);

        // Simultaneous press on all channels
        swRaw = '1;
        for (int k = 0; k < 12; k++) cycle("sim_idle");
        swRaw = '0;
        watch("sim", 12, 3'b111, 1'b0, fe, np);
        chk("sim.edge", 32'(fe), 32'd6);
        chk("sim.count", 32'(np), 32'd1);
        chk("sim.level", 32'(swLevel), 32'd0);

        // Reset mid-debounce, CH held low through the reset
        swRaw = '1;
        for (int k = 0; k < 12; k++) cycle("rmid_idle");
        swRaw[0] = 1'b0;
        for (int k = 0; k < 4; k++) cycle("rmid_wait");
        chk("rmid.busy", 32'(swBusy[0]), 32'd1);
        do_reset("rmid");
        watch("rmid_post", 12, 3'b001, 1'b0, fe, np);
        chk("rmid.edge", 32'(fe), 32'd6);
        chk("rmid.count", 32'(np), 32'd1);

        // Randomized hold lengths per channel: mixes bounces and accepted changes
        begin
            int hold[NSW];
            for (int i = 0; i < NSW; i++) hold[i] = 0;
            for (int k = 0; k < 3000; k++) begin
                for (int i = 0; i < NSW; i++) begin
                    if (hold[i] == 0) begin
                        swRaw[i] = 1'($urandom_range(0, 1));
                        hold[i]  = int'($urandom_range(1, 9));
                    end
                    hold[i]--;
                end
                if ($urandom_range(0, 399) == 0) do_reset("rnd");
                else cycle("rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
